spi_flash_boot_rom: RTL

//  Parametrised successor of the instruction ROM: at power-up it copies a program image from SPI

---
 rtl/spi_flash_boot_rom.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_boot_rom.sv
// Boot ROM that copies a program image from SPI flash (wake 0xAB, READ 0x03, mode 0) into RAM
// and serves it as a one-cycle-latency instruction store; ready gates the CPU.
module spi_flash_boot_rom #(
  parameter int          WORD_WIDTH   = 16,
  parameter int          WORDS        = 4096,
  parameter logic [23:0] FLASH_OFFSET = 24'h100000,
  parameter logic [23:0] BANK_STRIDE  = 24'h010000,
  parameter int          BANKS        = 4,
  parameter int          SCLK_DIV     = 1,
  parameter int          WAKE_CYCLES  = 64,
  localparam int         BANK_W       = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BANK_W-1:0]     bank,
  input  logic                  reload,
  output logic                  ready,
  input  logic [15:0]           address,
  output logic [WORD_WIDTH-1:0] instruction,
  output logic                  spi_cs,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);

  typedef enum logic [2:0] {S_WAKE, S_WAKE_WAIT, S_GAP, S_CMD, S_DATA, S_DONE} state_e;

  state_e                state_q, state_d;
  logic                  cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, ready_q, ready_d;
  logic                  wr_pend_q, wr_pend_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [5:0]            bit_q, bit_d;
  logic [31:0]           wait_q, wait_d;
  logic [31:0]           shift_q, shift_d;
  logic [BIT_W-1:0]      word_bit_q, word_bit_d;
  logic [IDX_W-1:0]      word_idx_q, word_idx_d;
  logic [BANK_W-1:0]     bank_q, bank_d;
  logic [WORD_WIDTH-1:0] rx_q, rx_d;
  logic [WORD_WIDTH-1:0] instruction_q, instruction_d;
  logic [WORD_WIDTH-1:0] ram [WORDS];

  logic        in_xfer_state, xfer, tick, rise, fall;
  logic        wake_end, cmd_end, word_done, data_end, wait_end, gap_end, reload_go;
  logic [23:0] flash_addr;

  assign in_xfer_state = (state_q == S_WAKE) || (state_q == S_CMD) || (state_q == S_DATA);
  assign xfer      = in_xfer_state && !cs_q;
  assign tick      = xfer && (div_q == DIV_MAX);
  assign rise      = tick && !sclk_q;
  assign fall      = tick && sclk_q;
  assign wake_end  = (state_q == S_WAKE) && fall && (bit_q == 6'd8);
  assign cmd_end   = (state_q == S_CMD) && fall && (bit_q == 6'd32);
  assign word_done = (state_q == S_DATA) && wr_pend_q;
  assign data_end  = word_done && (word_idx_q == LAST_IDX);
  assign wait_end  = (state_q == S_WAKE_WAIT) && (wait_q >= 32'(WAKE_CYCLES));
  assign gap_end   = (state_q == S_GAP) && (wait_q >= 32'd1);
  assign reload_go = (state_q == S_DONE) && reload;
  assign flash_addr = FLASH_OFFSET + 24'(bank_q) * BANK_STRIDE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_WAKE;
      cs_q          <= 1'b1;
      sclk_q        <= 1'b0;
      mosi_q        <= 1'b0;
      ready_q       <= 1'b0;
      wr_pend_q     <= 1'b0;
      div_q         <= '0;
      bit_q         <= '0;
      wait_q        <= '0;
      shift_q       <= {8'hAB, 24'h0};
      word_bit_q    <= '0;
      word_idx_q    <= '0;
      bank_q        <= bank;
      instruction_q <= '0;
    end else begin
      state_q       <= state_d;
      cs_q          <= cs_d;
      sclk_q        <= sclk_d;
      mosi_q        <= mosi_d;
      ready_q       <= ready_d;
      wr_pend_q     <= wr_pend_d;
      div_q         <= div_d;
      bit_q         <= bit_d;
      wait_q        <= wait_d;
      shift_q       <= shift_d;
      word_bit_q    <= word_bit_d;
      word_idx_q    <= word_idx_d;
      bank_q        <= bank_d;
      instruction_q <= instruction_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_q <= rx_d;
    if (reset && word_done) ram[word_idx_q] <= rx_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAKE:      if (wake_end)  state_d = S_WAKE_WAIT;
      S_WAKE_WAIT: if (wait_end)  state_d = S_CMD;
      S_GAP:       if (gap_end)   state_d = S_CMD;
      S_CMD:       if (cmd_end)   state_d = S_DATA;
      S_DATA:      if (data_end)  state_d = S_DONE;
      S_DONE:      if (reload_go) state_d = S_GAP;
      default:                    state_d = S_WAKE;
    endcase
  end

  always_comb begin
    cs_d       = cs_q;
    sclk_d     = sclk_q;
    div_d      = div_q;
    bit_d      = bit_q;
    wait_d     = wait_q;
    shift_d    = shift_q;
    word_bit_d = word_bit_q;
    word_idx_d = word_idx_q;
    wr_pend_d  = 1'b0;
    rx_d       = rx_q;
    bank_d     = bank_q;
    ready_d    = (state_q == S_DONE) && !reload;

    // A transfer state entered with CS high spends one clk dropping CS before clocking.
    if (in_xfer_state && cs_q) begin
      cs_d  = 1'b0;
      div_d = '0;
    end
    if (xfer) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) sclk_d = !sclk_q;
    end
    if (rise) begin
      if (state_q == S_DATA) begin
        rx_d = {rx_q[WORD_WIDTH-2:0], spi_miso};
        if (word_bit_q == LAST_BIT) begin
          word_bit_d = '0;
          wr_pend_d  = 1'b1;
        end else begin
          word_bit_d = word_bit_q + 1'b1;
        end
      end else begin
        bit_d = bit_q + 6'd1;
      end
    end
    if (fall && state_q != S_DATA) shift_d = {shift_q[30:0], 1'b0};
    if (word_done) word_idx_d = word_idx_q + 1'b1;
    if (state_q == S_WAKE_WAIT || state_q == S_GAP) wait_d = wait_q + 32'd1;

    if (wake_end) begin
      cs_d   = 1'b1;
      wait_d = '0;
    end
    if (wait_end || gap_end) begin
      shift_d = {8'h03, flash_addr};
      bit_d   = '0;
    end
    if (cmd_end) begin
      word_bit_d = '0;
      word_idx_d = '0;
    end
    // End the image as soon as the last word is stored; SCLK is parked low with CS.
    if (data_end) begin
      cs_d   = 1'b1;
      sclk_d = 1'b0;
      div_d  = '0;
    end
    if (reload_go) begin
      bank_d = bank;
      wait_d = '0;
    end

    mosi_d = (!cs_d && (state_d == S_WAKE || state_d == S_CMD)) ? shift_d[31] : 1'b0;

    instruction_d = '0;
    if (ready_q && (32'(address) < 32'(WORDS))) instruction_d = ram[address[IDX_W-1:0]];
  end

  assign ready       = ready_q;
  assign instruction = instruction_q;
  assign spi_cs      = cs_q;
  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;

endmodule
